// File: rtl/matmul_pkg.sv
// Shared widths, FSM states and lane packing helpers for the 4x4 matmul feeder.
// Lane k of a 128-bit row sits at bits [127-32k -: 32].
package matmul_pkg;
    localparam int N      = 4;
    localparam int ELEM_W = 32;
    localparam int ROW_W  = N * ELEM_W;

    typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, READ, DONE} state_t;

    function automatic logic [ELEM_W-1:0] getLane(input logic [ROW_W-1:0] row, input logic [1:0] k);
        return row[ROW_W - 1 - ELEM_W * int'(k) -: ELEM_W];
    endfunction

    function automatic logic [ROW_W-1:0] setLane(input logic [ROW_W-1:0] row, input logic [1:0] k,
                                                 input logic [ELEM_W-1:0] v);
        logic [ROW_W-1:0] res;
        res = row;
        res[ROW_W - 1 - ELEM_W * int'(k) -: ELEM_W] = v;
        return res;
    endfunction
endpackage

// File: rtl/matmul_skew_lane.sv
// Picks element (t - LANE) of a 4-element vector, or 0 when that index falls outside 0..3.
// Purely combinational.
module matmul_skew_lane
    import matmul_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [2:0]        t,
    input  logic [ROW_W-1:0]  vec,
    output logic [ELEM_W-1:0] elem
);
    logic [3:0] k;

    // Negative offsets wrap to values >= 4 and are therefore zeroed too.
    always_comb begin
        k    = {1'b0, t} - 4'(LANE);
        elem = (k < 4'(N)) ? getLane(vec, k[1:0]) : '0;
    end
endmodule

// File: rtl/matmul_feeder.sv
// Feeds skewed L/R lanes to the 4x4 systolic FU and collects D = L x R; done at cycle 8+DRAIN_CYCLES+4 after start.
// No backpressure: a READ cycle without output_rdy leaves D untouched and sets sticky err. MATMUL_FEEDER_ACCUM_EN makes READ accumulate into D.
module matmul_feeder
    import matmul_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int READ_BASE    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [1:0]         wr_row,
    input  logic [ROW_W-1:0]   wr_data,
    input  logic               start,
    input  logic [1:0]         rd_row,
    output logic [ROW_W-1:0]   rd_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               input_start,
    output logic [ROW_W-1:0]   inA_flat,
    output logic [ROW_W-1:0]   inB_flat,
    output logic [3:0]         counter,
    input  logic [ROW_W-1:0]   outD_flat,
    input  logic               output_rdy
);
    localparam logic [7:0] STREAM_LAST = 8'(2 * N - 2);

    state_t             state;
    logic [7:0]         cnt;
    logic [ROW_W-1:0]   lBuf [N];
    logic [ROW_W-1:0]   rBuf [N];
    logic [ROW_W-1:0]   dBuf [N];
    logic [ROW_W-1:0]   rCols [N];
    logic [ELEM_W-1:0]  skewA [N];
    logic [ELEM_W-1:0]  skewB [N];
    logic [ELEM_W-1:0]  colVal [N];
    logic [2:0]         tNext;
    logic               laneVld;
    logic [1:0]         readCol;

    // Lanes are registered, so the skew muxes look one stream step ahead.
    assign tNext   = (state == START) ? 3'd0 : cnt[2:0] + 3'd1;
    assign laneVld = (state == START) || (state == STREAM && cnt != STREAM_LAST);
    assign readCol = cnt[1:0];
    assign rd_data = dBuf[rd_row];

    for (genvar g = 0; g < N; g++) begin : gLane
        for (genvar k = 0; k < N; k++) begin : gCol
            assign rCols[g][ROW_W - 1 - ELEM_W * k -: ELEM_W] = rBuf[k][ROW_W - 1 - ELEM_W * g -: ELEM_W];
        end
        matmul_skew_lane #(.LANE(g)) uSkewA (.t(tNext), .vec(rCols[g]), .elem(skewA[g]));
        matmul_skew_lane #(.LANE(g)) uSkewB (.t(tNext), .vec(lBuf[g]),  .elem(skewB[g]));
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
`ifdef MATMUL_FEEDER_ACCUM_EN
            colVal[r] = getLane(dBuf[r], readCol) + getLane(outD_flat, 2'(r));
`else
            colVal[r] = getLane(outD_flat, 2'(r));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            input_start <= 1'b0;
            counter     <= '0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            input_start <= 1'b0;
            counter     <= '0;
            case (state)
                IDLE: if (start) begin
                    state       <= START;
                    busy        <= 1'b1;
                    input_start <= 1'b1;
                    err         <= 1'b0;
                end
                START: begin
                    state <= STREAM;
                    cnt   <= '0;
                end
                STREAM: if (cnt == STREAM_LAST) begin
                    state <= DRAIN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DRAIN: if (cnt == 8'(DRAIN_CYCLES - 1)) begin
                    state   <= READ;
                    cnt     <= '0;
                    counter <= 4'(READ_BASE);
                end else begin
                    cnt <= cnt + 8'd1;
                end
                READ: begin
                    if (!output_rdy) err <= 1'b1;
                    if (readCol == 2'(N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        counter <= 4'(READ_BASE + int'(readCol) + 1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inA_flat <= '0;
            inB_flat <= '0;
        end else begin
            for (int g = 0; g < N; g++) begin
                inA_flat[ROW_W - 1 - ELEM_W * g -: ELEM_W] <= laneVld ? skewA[g] : '0;
                inB_flat[ROW_W - 1 - ELEM_W * g -: ELEM_W] <= laneVld ? skewB[g] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                lBuf[r] <= '0;
                rBuf[r] <= '0;
                dBuf[r] <= '0;
            end
        end else begin
            if (wr_en && state == IDLE) begin
                if (wr_sel) rBuf[wr_row] <= wr_data;
                else        lBuf[wr_row] <= wr_data;
            end
            if (state == READ && output_rdy) begin
                for (int r = 0; r < N; r++) dBuf[r] <= setLane(dBuf[r], readCol, colVal[r]);
            end
        end
    end
endmodule

// File: tb/tb_matmul_feeder.sv
// Directed bench for matmul_feeder with a behavioural output-stationary 4x4 systolic FU.
module tb_matmul_feeder;
    localparam int DRAIN  = 4;
    localparam int RBASE  = 7;
    localparam int DONE_N = 8 + DRAIN + 4;

    logic         clk = 1'b0;
    logic         rst, wr_en, wr_sel, start;
    logic [1:0]   wr_row, rd_row;
    logic [127:0] wr_data, rd_data, inA_flat, inB_flat, outD_flat;
    logic         busy, done, err, input_start, output_rdy;
    logic [3:0]   counter;
    logic         fuStall;

    matmul_feeder #(.DRAIN_CYCLES(DRAIN), .READ_BASE(RBASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_data(wr_data),
        .start(start), .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .input_start(input_start), .inA_flat(inA_flat), .inB_flat(inB_flat), .counter(counter),
        .outD_flat(outD_flat), .output_rdy(output_rdy)
    );

    always #5 clk = ~clk;

    // Systolic FU: A flows down columns, B flows right along rows, PEs accumulate in place.
    logic [31:0] acc [4][4];
    logic [31:0] aReg [4][4];
    logic [31:0] bReg [4][4];

    function automatic logic [31:0] aIn(input int i, input int j);
        return (i == 0) ? inA_flat[127 - 32 * j -: 32] : aReg[i - 1][j];
    endfunction

    function automatic logic [31:0] bIn(input int i, input int j);
        return (j == 0) ? inB_flat[127 - 32 * i -: 32] : bReg[i][j - 1];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                aReg[i][j] <= input_start ? 32'd0 : aIn(i, j);
                bReg[i][j] <= input_start ? 32'd0 : bIn(i, j);
                acc[i][j]  <= input_start ? 32'd0 : acc[i][j] + aIn(i, j) * bIn(i, j);
            end
        end
    end

    always_comb begin
        int c;
        c          = int'(counter) - RBASE;
        outD_flat  = '0;
        output_rdy = 1'b0;
        if (c >= 0 && c < 4) begin
            output_rdy = !fuStall;
            for (int r = 0; r < 4; r++) outD_flat[127 - 32 * r -: 32] = acc[r][c];
        end
    end

    typedef struct {
        logic [3:0][127:0] l;
        logic [3:0][127:0] r;
        logic [3:0][127:0] d;
    } vec_t;

    vec_t              vecs [3];
    logic [3:0][127:0] expD;
    logic [127:0]      constRow;
    int                applied = 0;
    int                miscompares = 0;
    int                doneAt;
    logic              isAt0, errN0, errN12, errN13;
    logic [3:0]        cntRead;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkD(input string tag, input logic [3:0][127:0] e);
        for (int r = 0; r < 4; r++) begin
            rd_row = 2'(r);
            #1;
            check($sformatf("%s_row%0d", tag, r), rd_data, e[r]);
        end
    endtask

    function automatic logic [127:0] addRow(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] s;
        for (int k = 0; k < 4; k++) s[127 - 32 * k -: 32] = a[127 - 32 * k -: 32] + b[127 - 32 * k -: 32];
        return s;
    endfunction

    task automatic absorb(input logic [3:0][127:0] p);
        for (int r = 0; r < 4; r++) begin
`ifdef MATMUL_FEEDER_ACCUM_EN
            expD[r] = addRow(expD[r], p[r]);
`else
            expD[r] = p[r];
`endif
        end
    endtask

    task automatic writeRow(input logic sel, input logic [1:0] row, input logic [127:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = row; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Start a run (optionally writing R row 3 in the same cycle) and watch it cycle by cycle.
    task automatic runOp(input logic doWr, input logic [127:0] wrD, input int stGl, input int wrGl, input int rstAt);
        doneAt = -1; isAt0 = 1'b0; cntRead = '0; errN0 = 1'b1; errN12 = 1'b1; errN13 = 1'b0;
        wr_en = doWr; wr_sel = 1'b1; wr_row = 2'd3; wr_data = wrD; start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (n == 0) begin isAt0 = input_start; errN0 = err; end
            if (n == 8 + DRAIN) begin cntRead = counter; errN12 = err; end
            if (n == 9 + DRAIN) errN13 = err;
            if (done) begin doneAt = n; break; end
            start = (n == stGl);
            wr_en = (n == wrGl); wr_sel = 1'b0; wr_row = 2'd0; wr_data = '1;
            rst   = (n == rstAt);
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            if (rst) begin rst = 1'b0; return; end
        end
        if (doneAt >= 0) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0;
        start = 1'b0; rd_row = '0; fuStall = 1'b0; expD = '0;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                vecs[0].l[i][127 - 32 * j -: 32] = 32'(i == j);
                vecs[0].r[i][127 - 32 * j -: 32] = 32'(4 * i + j + 1);
                vecs[0].d[i][127 - 32 * j -: 32] = 32'(4 * i + j + 1);
                vecs[1].l[i][127 - 32 * j -: 32] = 32'd1;
                vecs[1].r[i][127 - 32 * j -: 32] = 32'd1;
                vecs[1].d[i][127 - 32 * j -: 32] = 32'd4;
                vecs[2].l[i][127 - 32 * j -: 32] = 32'(i + 1);
                vecs[2].r[i][127 - 32 * j -: 32] = 32'(j + 1);
                vecs[2].d[i][127 - 32 * j -: 32] = 32'(4 * (i + 1) * (j + 1));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_input_start", 128'(input_start), 128'(0));
        check("rst_counter", 128'(counter), 128'(0));
        check("rst_inA", inA_flat, 128'(0));
        check("rst_inB", inB_flat, 128'(0));
        checkD("rst_D", expD);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            for (int r = 0; r < 4; r++) writeRow(1'b0, 2'(r), vecs[v].l[r]);
            for (int r = 0; r < 3; r++) writeRow(1'b1, 2'(r), vecs[v].r[r]);
            runOp(1'b1, vecs[v].r[3], -1, -1, -1);
            check($sformatf("v%0d_done_cycle", v), 128'(doneAt), 128'(DONE_N));
            check($sformatf("v%0d_input_start_n0", v), 128'(isAt0), 128'(1));
            check($sformatf("v%0d_counter_read0", v), 128'(cntRead), 128'(RBASE));
            check($sformatf("v%0d_err", v), 128'(err), 128'(0));
            absorb(vecs[v].d);
            checkD($sformatf("v%0d_D", v), expD);
        end

        // start during STREAM and an L write during DRAIN must both be ignored
        runOp(1'b0, '0, 3, 9, -1);
        check("glitch_done_cycle", 128'(doneAt), 128'(DONE_N));
        absorb(vecs[2].d);
        checkD("glitch_D", expD);

        // FU never ready: err rises after the first READ cycle, D is kept, done still pulses
        fuStall = 1'b1;
        runOp(1'b0, '0, -1, -1, -1);
        fuStall = 1'b0;
        check("stall_done_cycle", 128'(doneAt), 128'(DONE_N));
        check("stall_err_read0", 128'(errN12), 128'(0));
        check("stall_err_read1", 128'(errN13), 128'(1));
        check("stall_err_sticky", 128'(err), 128'(1));
        check("stall_busy_after", 128'(busy), 128'(0));
        checkD("stall_D", expD);

        // reset at n=5; the start that opens this run must also clear err
        runOp(1'b0, '0, -1, -1, 5);
        check("midrst_err_cleared_by_start", 128'(errN0), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_counter", 128'(counter), 128'(0));
        check("midrst_inA", inA_flat, 128'(0));
        expD = '0;
        checkD("midrst_D", expD);

        for (int r = 0; r < 4; r++) writeRow(1'b0, 2'(r), vecs[1].l[r]);
        for (int r = 0; r < 4; r++) writeRow(1'b1, 2'(r), vecs[1].r[r]);
        runOp(1'b0, '0, -1, -1, -1);
        check("ones1_done_cycle", 128'(doneAt), 128'(DONE_N));
        runOp(1'b0, '0, -1, -1, -1);
        check("ones2_done_cycle", 128'(doneAt), 128'(DONE_N));
`ifdef MATMUL_FEEDER_ACCUM_EN
        constRow = {4{32'd8}};
`else
        constRow = {4{32'd4}};
`endif
        checkD("ones_twice_D", {4{constRow}});

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
